// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES byte-stream path.
//   BYTE_W_DEFAULT : default byte width for stream blocks
//   MODE_FIXED     : arbiter mode, forward only the selected channel
//   MODE_RR        : arbiter mode, round-robin over pending channels
//   byte_t         : default-width byte type
package aes_stream_pkg;

    localparam int BYTE_W_DEFAULT = 8;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef logic [BYTE_W_DEFAULT-1:0] byte_t;

endpackage

// File: rtl/byte_chan_buffer.sv
// One-entry holding buffer for a single producer channel.
//   clk, rst      : clock, asynchronous active-high reset
//   in_ready      : one-cycle strobe, in_byte is a new byte
//   in_byte       : producer data
//   grant         : the arbiter is forwarding this buffer's byte this cycle
//   clr_overflow  : synchronous clear of the sticky drop flag
//   pend          : buffer holds a byte not yet forwarded
//   data          : buffered byte
//   overflow      : sticky, a byte arrived while full and not being drained
module byte_chan_buffer
    import aes_stream_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_ready,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              grant,
    input  logic              clr_overflow,
    output logic              pend,
    output logic [BYTE_W-1:0] data,
    output logic              overflow
);

    logic              pend_q, pend_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        pend_d     = pend_q;
        data_d     = data_q;
        overflow_d = overflow_q;

        if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        if (in_ready) begin
            // A granted buffer is emptied this cycle, so it can take the
            // new byte at the same edge; this is what lets one channel run
            // at a byte per cycle.
            if (!pend_q || grant) begin
                data_d = in_byte;
                pend_d = 1'b1;
            end else begin
                // Full and not draining: keep the old byte, flag the loss.
                // Set after the clear so a same-cycle drop wins.
                overflow_d = 1'b1;
            end
        end else if (grant) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign pend     = pend_q;
    assign data     = data_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/byte_stream_arbiter.sv
// N-channel byte-stream selector feeding the AES byte consumer.
// Each channel has a one-entry buffer; one buffered byte per cycle is
// forwarded to a registered output, chosen by fixed select or round-robin.
//   clk, rst      : clock, asynchronous active-high reset
//   mode          : MODE_FIXED (0) or MODE_RR (1)
//   select        : channel forwarded in fixed mode (>= N_CHAN: none)
//   in_byte       : channel i data at [i*BYTE_W +: BYTE_W]
//   in_ready      : per-channel one-cycle byte strobe
//   in_busy       : per-channel buffer occupied
//   clr_overflow  : synchronous clear of all overflow bits
//   overflow      : sticky per-channel dropped-byte flags
//   out_byte      : registered output byte
//   out_ready     : one-cycle strobe, out_byte is new
//   out_chan      : source channel of out_byte (only with BYTE_ARB_TAG_EN)
// Build option: define BYTE_ARB_TAG_EN to add the out_chan port/register.
//
// Handshake: in_ready is a one-cycle strobe with no acknowledge. in_busy is
// registered advice to the producer; a strobe while busy is accepted only if
// the channel is granted in that same cycle, otherwise the byte is dropped
// and overflow set. out_ready has no back-pressure: the consumer must take
// out_byte in the cycle out_ready is high.
module byte_stream_arbiter
    import aes_stream_pkg::*;
#(
    parameter  int N_CHAN = 2,
    parameter  int BYTE_W = BYTE_W_DEFAULT,
    localparam int SEL_W  = $clog2(N_CHAN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    input  logic [N_CHAN*BYTE_W-1:0] in_byte,
    input  logic [N_CHAN-1:0]        in_ready,
    output logic [N_CHAN-1:0]        in_busy,
    output logic [BYTE_W-1:0]        out_byte,
    output logic                     out_ready,
    output logic [N_CHAN-1:0]        overflow,
    input  logic                     clr_overflow
`ifdef BYTE_ARB_TAG_EN
    ,
    output logic [SEL_W-1:0]         out_chan
`endif
);

    localparam logic [SEL_W:0] N_CHAN_EXT = (SEL_W+1)'(N_CHAN);

    logic [N_CHAN-1:0] pend;
    logic [N_CHAN-1:0] grant_vec;
    logic [BYTE_W-1:0] chan_data [N_CHAN];

    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W:0]    scan_sum;
    logic [SEL_W-1:0]  scan_idx;

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [BYTE_W-1:0] out_byte_q, out_byte_d;
    logic              out_ready_q, out_ready_d;

    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        assign grant_vec[i] = grant_valid && (grant_idx == SEL_W'(i));

        byte_chan_buffer #(
            .BYTE_W (BYTE_W)
        ) u_buf (
            .clk          (clk),
            .rst          (rst),
            .in_ready     (in_ready[i]),
            .in_byte      (in_byte[i*BYTE_W +: BYTE_W]),
            .grant        (grant_vec[i]),
            .clr_overflow (clr_overflow),
            .pend         (pend[i]),
            .data         (chan_data[i]),
            .overflow     (overflow[i])
        );
    end

    // Grant decision. In round-robin the scan runs from ptr+N down to
    // ptr+1 and keeps overwriting, so the last hit is the channel closest
    // after ptr. ptr+k stays below 2*N_CHAN, so one subtract wraps it.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;

        if (mode == MODE_FIXED) begin
            if (({1'b0, select} < N_CHAN_EXT) && pend[select]) begin
                grant_valid = 1'b1;
                grant_idx   = select;
            end
        end else begin
            for (int k = N_CHAN; k >= 1; k--) begin
                scan_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (scan_sum >= N_CHAN_EXT) begin
                    scan_sum = scan_sum - N_CHAN_EXT;
                end
                scan_idx = scan_sum[SEL_W-1:0];
                if (pend[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_ready_d = grant_valid;
        out_byte_d  = out_byte_q;

        // Fixed mode leaves the rotation where it was, so switching back
        // to round-robin resumes after the last round-robin winner.
        if (mode == MODE_RR && grant_valid) begin
            ptr_d = grant_idx;
        end
        if (grant_valid) begin
            out_byte_d = chan_data[grant_idx];
        end
    end

    // ptr resets to the last channel so channel 0 is first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= SEL_W'(N_CHAN - 1);
            out_byte_q  <= '0;
            out_ready_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_byte_q  <= out_byte_d;
            out_ready_q <= out_ready_d;
        end
    end

`ifdef BYTE_ARB_TAG_EN
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    always_comb begin
        out_chan_d = out_chan_q;
        if (grant_valid) begin
            out_chan_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_chan_q <= '0;
        end else begin
            out_chan_q <= out_chan_d;
        end
    end

    assign out_chan = out_chan_q;
`endif

    assign in_busy   = pend;
    assign out_byte  = out_byte_q;
    assign out_ready = out_ready_q;

endmodule

// File: tb/tb_byte_stream_arbiter.sv
// Self-checking bench for byte_stream_arbiter with four channels.
// A reference model updated on each clock edge pushes every forwarded byte
// (tagged with its channel) into exp_q; a monitor on the falling edge pops
// and compares whenever out_ready is high, and also compares busy/overflow
// and the held output against the model state.
module tb_byte_stream_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int SW = 2;
    localparam int W  = SW + BW;

    // Clock / reset and DUT signals
    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [SW-1:0] select;
    logic [N*BW-1:0] in_byte;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  in_busy;
    logic [BW-1:0] out_byte;
    logic          out_ready;
    logic [N-1:0]  overflow;
    logic          clr_overflow;
`ifdef BYTE_ARB_TAG_EN
    logic [SW-1:0] out_chan;
`endif

    always #5 clk = ~clk;

    byte_stream_arbiter #(
        .N_CHAN (N),
        .BYTE_W (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .select       (select),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .in_busy      (in_busy),
        .out_byte     (out_byte),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef BYTE_ARB_TAG_EN
        ,
        .out_chan     (out_chan)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel slot with a pending flag, a sticky drop
    // flag, and a rotating "last winner" index for round-robin.
    logic [W-1:0]  exp_q[$];
    logic [BW-1:0] m_buf [N];
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_ov;
    int            m_ptr;
    int            m_g;
    logic          m_strobe;
    logic [BW-1:0] m_last_byte;
`ifdef BYTE_ARB_TAG_EN
    int            m_last_chan;
`endif

    function automatic int pick_winner(input logic [N-1:0] pend, input logic md,
                                       input int sel, input int ptr);
        if (md == 1'b0) begin
            if (sel < N && pend[sel]) return sel;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend      = '0;
            m_ov        = '0;
            m_ptr       = N - 1;
            m_strobe    = 1'b0;
            m_last_byte = '0;
`ifdef BYTE_ARB_TAG_EN
            m_last_chan = 0;
`endif
            for (int i = 0; i < N; i++) m_buf[i] = '0;
            exp_q.delete();
        end else begin
            m_g      = pick_winner(m_pend, mode, int'(select), m_ptr);
            m_strobe = (m_g >= 0);
            if (m_g >= 0) begin
                m_last_byte = m_buf[m_g];
`ifdef BYTE_ARB_TAG_EN
                m_last_chan = m_g;
`endif
                exp_q.push_back({SW'(m_g), m_buf[m_g]});
                if (mode) m_ptr = m_g;
            end
            if (clr_overflow) m_ov = '0;
            for (int i = 0; i < N; i++) begin
                if (in_ready[i]) begin
                    if (!m_pend[i] || m_g == i) begin
                        m_buf[i]  = in_byte[i*BW +: BW];
                        m_pend[i] = 1'b1;
                    end else begin
                        m_ov[i] = 1'b1;
                    end
                end else if (m_g == i) begin
                    m_pend[i] = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        check("out_ready", out_ready, m_strobe);
        if (out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: out_byte 0x%0h, expected no output", out_byte);
            end else begin
                e = exp_q.pop_front();
                check("sb_byte", out_byte, e[BW-1:0]);
`ifdef BYTE_ARB_TAG_EN
                check("sb_chan", out_chan, e[W-1:BW]);
`endif
            end
        end
        check("out_byte_held", out_byte, m_last_byte);
        check("in_busy", in_busy, m_pend);
        check("overflow", overflow, m_ov);
`ifdef BYTE_ARB_TAG_EN
        check("out_chan_held", out_chan, m_last_chan);
`endif
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_byte(input int ch, input logic [BW-1:0] v);
        in_byte[ch*BW +: BW] = v;
    endtask

    task automatic strobe(input logic [N-1:0] rdy);
        in_ready = rdy;
        tick();
        in_ready = '0;
    endtask

    initial begin
        int cnt;
        rst          = 1'b1;
        mode         = 1'b0;
        select       = '0;
        in_byte      = '0;
        in_ready     = '0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        check("reset_out_byte", out_byte, 0);
        check("reset_busy", in_busy, 0);

        // Fixed select of channel 1: only 0x3C goes out, ch0 stays buffered.
        mode   = 1'b0;
        select = 2'd1;
        set_byte(0, 8'hA5);
        set_byte(1, 8'h3C);
        strobe(4'b0011);
        tick();
        check("fixed_out_ready", out_ready, 1);
        check("fixed_out_byte", out_byte, 8'h3C);
        tick();
        check("fixed_ch0_busy", in_busy, 4'b0001);
        select = 2'd0;
        idle(3);

        // Reset while bytes are pending.
        select = 2'd3;
        set_byte(1, 8'h11);
        set_byte(2, 8'h22);
        strobe(4'b0110);
        idle(1);
        check("pre_reset_busy", in_busy, 4'b0110);
        rst = 1'b1;
        #1;
        check("rst_out_ready", out_ready, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_busy", in_busy, 0);
        check("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;

        // Round-robin, all channels at once: ch0..ch3 on consecutive cycles.
        mode = 1'b1;
        set_byte(0, 8'h10);
        set_byte(1, 8'h21);
        set_byte(2, 8'h32);
        set_byte(3, 8'h43);
        strobe(4'b1111);
        tick();
        check("rr_first_ch0", out_byte, 8'h10);
        tick();
        check("rr_second_ch1", out_byte, 8'h21);
        tick();
        check("rr_third_ch2", out_byte, 8'h32);
        tick();
        check("rr_fourth_ch3", out_byte, 8'h43);
        idle(3);

        // Single channel streaming every cycle.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            set_byte(2, 8'(i));
            in_ready = 4'b0100;
            tick();
            if (out_ready) cnt++;
        end
        in_ready = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (out_ready) cnt++;
        end
        check("stream_count", cnt, 16);
        check("stream_no_overflow", overflow, 0);

        // Overflow on an ungranted channel, clear racing a new drop.
        mode   = 1'b0;
        select = 2'd0;
        set_byte(1, 8'h5A);
        strobe(4'b0010);
        set_byte(1, 8'h6B);
        strobe(4'b0010);
        check("ovf_set", overflow[1], 1);
        clr_overflow = 1'b1;
        set_byte(1, 8'h7C);
        strobe(4'b0010);
        clr_overflow = 1'b0;
        check("ovf_clr_loses", overflow[1], 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);
        select = 2'd1;
        idle(2);

        // Round-robin bursts from ch3 then ch1 (channel tags checked by the monitor).
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_byte(3, 8'hC0 + 8'(i));
            strobe(4'b1000);
        end
        for (int i = 0; i < 3; i++) begin
            set_byte(1, 8'h90 + 8'(i));
            strobe(4'b0010);
        end
        idle(3);

        // Randomized traffic.
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [N-1:0] rdy;
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) select = SW'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) begin
                rdy[i] = ($urandom_range(0, 2) == 0);
                set_byte(i, BW'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 3) != 0) rdy = rdy & ~in_busy;
            in_ready     = rdy;
            clr_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        in_ready     = '0;
        clr_overflow = 1'b0;
        mode         = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || m_pend != 0); i++) tick();
        idle(1);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
